// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv_fetch_pkg
// Shared types and constants for the instruction fetch stage and the
// pipeline registers that follow it.
//   NOP_INSTR          : canonical RISC-V NOP (addi x0, x0, 0)
//   WORD_SIZE_POW      : log2 of the instruction word size in bytes
//   FETCH_ADDR_WIDTH   : byte-address width the IF/ID payload struct is built for
//   fetch_state_t      : fetch FSM states
//   if_id_t            : IF/ID payload {pc, pc_plus4, instr}
// ---------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int WORD_SIZE_POW = 2;

    localparam int FETCH_ADDR_WIDTH_POW = 6;
    localparam int FETCH_ADDR_WIDTH = 1 << FETCH_ADDR_WIDTH_POW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_ADDR_WIDTH-1:0] pc_plus4;
        logic [31:0]                 instr;
    } if_id_t;

    // True when a byte address sits on an instruction-word boundary.
    function automatic logic is_word_aligned(input logic [FETCH_ADDR_WIDTH-1:0] addr);
        return addr[WORD_SIZE_POW-1:0] == '0;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock/reset signal of the fetch stage:
//   memory side   : pc_out (to memory addr_in), instr_in (combinational data)
//   execute side  : redirect_valid_in, redirect_pc_in
//   decode side   : id_ready_in, if_valid_out, if_instr_out, if_pc_out,
//                   if_pc_plus4_out
//   fault report  : fetch_fault_out, fault_addr_out
// modport master : used by the fetch stage itself
// modport slave  : used by the surrounding environment (memory/execute/decode)
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [31:0]           instr_in;
    logic                  redirect_valid_in;
    logic [ADDR_WIDTH-1:0] redirect_pc_in;
    logic                  id_ready_in;
    logic                  if_valid_out;
    logic [31:0]           if_instr_out;
    logic [ADDR_WIDTH-1:0] if_pc_out;
    logic [ADDR_WIDTH-1:0] if_pc_plus4_out;
    logic                  fetch_fault_out;
    logic [ADDR_WIDTH-1:0] fault_addr_out;

    modport master (
        output pc_out,
        input  instr_in,
        input  redirect_valid_in,
        input  redirect_pc_in,
        input  id_ready_in,
        output if_valid_out,
        output if_instr_out,
        output if_pc_out,
        output if_pc_plus4_out,
        output fetch_fault_out,
        output fault_addr_out
    );

    modport slave (
        input  pc_out,
        output instr_in,
        output redirect_valid_in,
        output redirect_pc_in,
        output id_ready_in,
        input  if_valid_out,
        input  if_instr_out,
        input  if_pc_out,
        input  if_pc_plus4_out,
        input  fetch_fault_out,
        input  fault_addr_out
    );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register: a payload of WIDTH bits plus a valid bit.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture data_in and mark valid
//   flush      : drop the contents (valid=0, data=CLEAR_VAL); wins over load
//   data_in    : payload to capture
//   valid_out  : register holds a live payload
//   data_out   : registered payload
// With neither load nor flush the register holds.
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = CLEAR_VAL;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= CLEAR_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of a combinational instruction memory. Owns the PC,
// drives the memory address, captures the returned word into the IF/ID
// register with a valid/ready handshake toward decode, and handles
// redirects (with flush) and misaligned-redirect faults.
//   clk    : clock
//   reset  : synchronous active-high reset (overrides a simultaneous redirect)
//   bus    : instr_fetch_if.master carrying memory, redirect, decode and
//            fault signals
// Parameters:
//   ADDR_WIDTH_POW : log2 of the byte-address width
//   RESET_PC       : PC after reset, must be word aligned
// ---------------------------------------------------------------------------
module instr_fetch
    import rv_fetch_pkg::*;
#(
    parameter int                                 ADDR_WIDTH_POW = 6,
    parameter logic [(1 << ADDR_WIDTH_POW)-1:0]   RESET_PC       = '0
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

    // The IF/ID payload struct is sized by the package.
    if (ADDR_WIDTH_POW != FETCH_ADDR_WIDTH_POW) begin : g_bad_addr_width
        $error("instr_fetch: ADDR_WIDTH_POW does not match rv_fetch_pkg");
    end
    if (RESET_PC[WORD_SIZE_POW-1:0] != '0) begin : g_bad_reset_pc
        $error("instr_fetch: RESET_PC must be 4-byte aligned");
    end

    localparam if_id_t IF_ID_CLEAR = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;

    logic                  if_id_load;
    logic                  if_id_flush;
    logic                  if_id_valid;
    if_id_t                if_id_capture;
    if_id_t                if_id_data;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    assign if_id_capture = '{pc: pc_q, pc_plus4: pc_plus4, instr: bus.instr_in};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if_id_load   = 1'b0;
        if_id_flush  = 1'b0;

        if (bus.redirect_valid_in) begin
            // A redirect flushes regardless of decode readiness or state.
            if_id_flush = 1'b1;
            if (is_word_aligned(bus.redirect_pc_in)) begin
                pc_d    = bus.redirect_pc_in;
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                // PC is left where it was; only the fault is recorded.
                state_d      = FAULT;
                fault_d      = 1'b1;
                fault_addr_d = bus.redirect_pc_in;
            end
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    // Advance when the IF/ID slot is empty or being drained.
                    if (!if_id_valid || bus.id_ready_in) begin
                        if_id_load = 1'b1;
                        pc_d       = pc_plus4;
                    end
                end
                FAULT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    if_id_reg #(
        .WIDTH     ($bits(if_id_t)),
        .CLEAR_VAL (IF_ID_CLEAR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (if_id_load),
        .flush     (if_id_flush),
        .data_in   (if_id_capture),
        .valid_out (if_id_valid),
        .data_out  (if_id_data)
    );

    assign bus.pc_out          = pc_q;
    assign bus.if_valid_out    = if_id_valid;
    assign bus.if_instr_out    = if_id_data.instr;
    assign bus.if_pc_out       = if_id_data.pc;
    assign bus.if_pc_plus4_out = if_id_data.pc_plus4;
    assign bus.fetch_fault_out = fault_q;
    assign bus.fault_addr_out  = fault_addr_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of instruction memory. Owns the program counter and drives the memory's byte address. Samples the 32-bit instruction that memory returns combinationally in the same cycle, and registers it into an IF/ID pipeline register with a valid/ready handshake toward decode. Handles stalls, branch/jump redirects with flush, and a misaligned-target fault.

Parameters:
ADDR_WIDTH_POW, 6, address width as a power of 2 (ADDR_WIDTH = 1 << ADDR_WIDTH_POW = 64); must match instruction memory
RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned (elaboration-time assertion)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_out  output  ADDR_WIDTH  current fetch byte address, to instruction memory addr_in
instr_in  input  32  instruction word returned combinationally by memory for pc_out
redirect_valid_in  input  1  taken branch/jump from execute; wins over all other events except reset
redirect_pc_in  input  ADDR_WIDTH  redirect target byte address
id_ready_in  input  1  decode can accept the IF/ID contents this cycle
if_valid_out  output  1  IF/ID register holds a valid instruction
if_instr_out  output  32  registered instruction
if_pc_out  output  ADDR_WIDTH  registered PC of if_instr_out
if_pc_plus4_out  output  ADDR_WIDTH  registered if_pc_out + 4 (link value)
fetch_fault_out  output  1  misaligned redirect fault pending
fault_addr_out  output  ADDR_WIDTH  offending redirect target

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: pc <= RESET_PC; state <= IDLE; if_valid_out = 0; if_instr_out = NOP (32'h00000013); if_pc_out, if_pc_plus4_out, fault_addr_out = 0; fetch_fault_out = 0. Reset overrides all inputs, including a simultaneous redirect.
- pc_out is driven directly from the PC register. Memory is combinational, so instr_in is valid in the same cycle.
- FSM states: IDLE, RUN, FAULT.
  - IDLE: one bubble after reset; if_valid_out stays 0; goes to RUN on the next cycle.
  - RUN: normal fetch.
  - FAULT: fetch suspended until an aligned redirect arrives.
- Handshake, in RUN with no redirect:
  - Advance when !if_valid_out || id_ready_in: capture {pc, instr_in, pc+4} into IF/ID, if_valid_out <= 1, pc <= pc+4. This sustains one instruction per cycle.
  - Stall when if_valid_out && !id_ready_in: PC and IF/ID hold their values unchanged.
- Redirect (redirect_valid_in=1), in any non-reset state:
  - if_valid_out <= 0 (flush); IF/ID data regs <= NOP/0.
  - If redirect_pc_in[1:0] == 0: pc <= redirect_pc_in; state <= RUN. The first fetch of the target is captured next cycle, so latency from redirect to valid target = 2 edges.
  - If misaligned: state <= FAULT; fetch_fault_out <= 1; fault_addr_out <= redirect_pc_in; pc holds.
  - A redirect during a stall still flushes; id_ready_in is ignored that cycle.
- FAULT: if_valid_out stays 0; fetch_fault_out stays 1. An aligned redirect clears the fault and resumes RUN. A further misaligned redirect updates fault_addr_out.
- Arithmetic: pc+4 is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH; no overflow flag. Addresses beyond memory depth alias inside memory; this block does not check them.
- IDLE + redirect: the redirect applies; state goes to RUN or FAULT per alignment.

Decomposition:
- Package rv_fetch_pkg:
  - NOP_INSTR = 32'h00000013
  - WORD_SIZE_POW = 2
  - fetch_state_t enum {IDLE, RUN, FAULT}
  - if_id_t packed struct {pc, pc_plus4, instr}
- Sub-module if_id_reg: holds the IF/ID payload plus valid, with load/flush/hold controls. It is reused later for the other pipeline registers.
- The FSM and PC logic stay in instr_fetch.

Test Plan:
- Reset then release, id_ready_in=1, memory preloaded with words 0..3 -> if_valid_out=0 in the first cycle. Afterwards if_pc_out = 0, 4, 8, 12 on consecutive cycles, if_instr_out matches mem[0..3], and if_pc_plus4_out = 4, 8, 12, 16.
- Steady run, drop id_ready_in for 3 cycles while if_pc_out=8 -> pc_out holds 12 and if_pc_out holds 8 for 3 cycles. On re-raise, 12 follows with no instruction lost or duplicated.
- Redirect to 0x40 while stalled at if_pc_out=8 -> next cycle if_valid_out=0 and pc_out=0x40. The following cycle if_pc_out=0x40 with instr = mem[16].
- Redirect to 0x42 -> fetch_fault_out=1, fault_addr_out=0x42, and if_valid_out stays 0 for 5 cycles. Then redirect to 0x80 -> fault clears and if_pc_out=0x80 two edges later.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC then run -> if_pc_plus4_out=0 and the next pc_out=0 (wrap).
- Assert reset together with redirect_valid_in=1 mid-run -> pc_out=RESET_PC, if_valid_out=0, fetch_fault_out=0, and the redirect is ignored.
